sum_threshold_unit: RTL and testbench

// - Receiving end of the PE partial-sum packet stream: collects one 8-bit psum per contributing PE for the current

---
 rtl/sum_threshold_unit.sv | 95 +++++++++
 tb/tb_sum_threshold_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sum_threshold_unit.sv
// sum_threshold_unit: gathers one psum per PE slot, integrates into the neuron membrane, fires and emits a spike packet.
module sum_threshold_unit #(
  parameter int WIDTH = 35,
  parameter logic [3:0] ST_ADDR = 4'b0011,
  parameter logic [3:0] DEST_ADDR = 4'b1111,
  parameter logic [3:0] PE_BASE = 4'b0111,
  parameter int NUM_PE = 5,
  parameter int NUM_NEURON = 28,
  parameter int NUM_TSTEP = 2,
  parameter int THRESH = 64,
  parameter int MEM_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err_pkt,
  output logic             done
);
  localparam int IW = NUM_NEURON > 1 ? $clog2(NUM_NEURON) : 1;
  localparam int TW = NUM_TSTEP > 1 ? $clog2(NUM_TSTEP) : 1;
  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] UPDATE = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  logic [1:0] state;
  logic [NUM_PE-1:0] got, slot_mask;
  logic [10:0] sum;
  logic [IW-1:0] idx;
  logic [TW-1:0] tstep;
  logic [MEM_W-1:0] mem [NUM_NEURON];
  logic [3:0] slot;
  logic slot_ok, accept, good, spike, last_idx, last_ts;
  logic [MEM_W:0] p_raw;
  logic [MEM_W-1:0] p, p_next;
  logic unused_bits;
  assign unused_bits = ^in_data[26:8];
  // Out-of-range slots shift the single set bit off the top, so the mask is zero for bad sources.
  assign slot = in_data[34:31] - PE_BASE;
  assign slot_mask = NUM_PE'(1) << slot;
  assign slot_ok = |slot_mask;
  assign in_ready = !rst && state == COLLECT && !(|(got & slot_mask));
  assign accept = in_valid && in_ready;
  assign good = slot_ok && in_data[30:27] == ST_ADDR;
  assign p_raw = (MEM_W+1)'(mem[idx]) + (MEM_W+1)'(sum);
  assign p = p_raw[MEM_W] ? '1 : p_raw[MEM_W-1:0];
  assign spike = p >= MEM_W'(THRESH);
  assign p_next = spike ? p - MEM_W'(THRESH) : p;
  assign last_idx = idx == IW'(NUM_NEURON - 1);
  assign last_ts = tstep == TW'(NUM_TSTEP - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
      got <= '0;
      sum <= '0;
      idx <= '0;
      tstep <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      err_pkt <= 1'b0;
      done <= 1'b0;
      for (int i = 0; i < NUM_NEURON; i++) mem[i] <= '0;
    end else begin
      err_pkt <= accept && !good;
      done <= 1'b0;
      if (state == COLLECT) begin
        if (accept && good) begin
          sum <= sum + 11'(in_data[7:0]);
          got <= got | slot_mask;
          if ((got | slot_mask) == '1) state <= UPDATE;
        end
      end else if (state == UPDATE) begin
        mem[idx] <= p_next;
        out_data <= {ST_ADDR, DEST_ADDR, 3'b010, 8'(tstep), 10'(idx), 5'd0, spike};
        sum <= '0;
        got <= '0;
        state <= SEND;
      end else if (!out_valid) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        state <= COLLECT;
        idx <= last_idx ? '0 : idx + 1'b1;
        if (last_idx) tstep <= last_ts ? '0 : tstep + 1'b1;
        if (last_idx && last_ts) begin
          done <= 1'b1;
          for (int i = 0; i < NUM_NEURON; i++) mem[i] <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sum_threshold_unit.sv
// tb_sum_threshold_unit: directed checks of accumulation, threshold, stalls, error drops, backpressure, wrap and reset.
module tb_sum_threshold_unit;
  logic clk = 0, rst, in_valid, out_ready, in_ready, out_valid, err_pkt, done;
  logic [34:0] in_data, out_data;
  int errors = 0, checks = 0, done_cnt = 0;
  localparam logic [3:0] ST = 4'b0011, PB = 4'b0111;
  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt++;
  sum_threshold_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err_pkt(err_pkt), .done(done)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [34:0] pkt(input int n, input int ts, input logic s);
    return {4'b0011, 4'b1111, 3'b010, 8'(ts), 10'(n), 5'd0, s};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [3:0] src, input logic [3:0] dest, input logic [7:0] ps);
    int n = 0;
    in_data = {src, dest, src, 15'd0, ps};
    in_valid = 1;
    #1;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $error("FAIL put_timeout: observed in_ready=0 expected 1 within 100 cycles");
    end
    step();
    in_valid = 0;
  endtask
  task automatic put5(input logic [7:0] a, b, c, d, e);
    put(PB, ST, a);
    put(PB + 4'd1, ST, b);
    put(PB + 4'd2, ST, c);
    put(PB + 4'd3, ST, d);
    put(PB + 4'd4, ST, e);
  endtask
  task automatic wait_valid();
    int k = 0;
    while (!out_valid && k < 100) begin
      step();
      k++;
    end
  endtask
  task automatic get(input string tag, input int n, input int ts, input logic s);
    wait_valid();
    chk({tag, "_valid"}, out_valid, 1);
    chk(tag, out_data, pkt(n, ts, s));
    step();
  endtask
  initial begin
    rst = 1;
    in_valid = 0;
    in_data = '0;
    out_ready = 1;
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err_pkt, 0);
    chk("rst_done", done, 0);
    rst = 0;
    #1;
    chk("ready_after_rst", in_ready, 1);
    // neuron 0, timestep 0, with dropped bad packets mixed in
    put(PB, ST, 10);
    put(4'he, ST, 30);
    chk("bad_src_err", err_pkt, 1);
    step();
    chk("err_one_cycle", err_pkt, 0);
    put(PB + 4'd1, 4'b0101, 30);
    chk("bad_dest_err", err_pkt, 1);
    put(PB + 4'd1, ST, 10);
    put(PB + 4'd2, ST, 10);
    put(PB + 4'd3, ST, 10);
    put(PB + 4'd4, ST, 10);
    chk("lat_t0", out_valid, 0);
    step();
    chk("lat_t1", out_valid, 0);
    step();
    chk("lat_t2", out_valid, 1);
    chk("send_not_ready", in_ready, 0);
    get("n0_t0", 0, 0, 0);
    // neuron 1: duplicate slot 2 stalls, exact sum 64
    put(PB + 4'd2, ST, 14);
    put(PB, ST, 14);
    in_data = {PB + 4'd2, ST, PB + 4'd2, 15'd0, 8'd20};
    in_valid = 1;
    #1;
    chk("dup_stall0", in_ready, 0);
    step();
    chk("dup_stall1", in_ready, 0);
    in_valid = 0;
    put(PB + 4'd1, ST, 12);
    put(PB + 4'd3, ST, 12);
    put(PB + 4'd4, ST, 12);
    in_data = {PB + 4'd2, ST, PB + 4'd2, 15'd0, 8'd20};
    in_valid = 1;
    #1;
    chk("dup_update_stall", in_ready, 0);
    get("n1_exact", 1, 0, 1);
    put(PB + 4'd2, ST, 20);
    put(PB, ST, 11);
    put(PB + 4'd1, ST, 11);
    put(PB + 4'd3, ST, 11);
    put(PB + 4'd4, ST, 11);
    get("n2_dup", 2, 0, 1);
    // neuron 3 under backpressure
    out_ready = 0;
    put5(0, 0, 0, 0, 0);
    wait_valid();
    chk("bp_data0", out_data, pkt(3, 0, 0));
    repeat (10) step();
    chk("bp_valid", out_valid, 1);
    chk("bp_data10", out_data, pkt(3, 0, 0));
    out_ready = 1;
    get("n3", 3, 0, 0);
    for (int n = 4; n < 28; n++) begin
      put5(0, 0, 0, 0, 0);
      get("t0_run", n, 0, 0);
    end
    // timestep 1: neuron 0 carries 50 from timestep 0
    put5(10, 10, 10, 10, 10);
    get("n0_t1_carry", 0, 1, 1);
    for (int n = 1; n < 27; n++) begin
      put5(0, 0, 0, 0, 0);
      get("t1_run", n, 1, 0);
    end
    put5(0, 0, 0, 0, 0);
    get("n27_t1", 27, 1, 0);
    chk("done_pulse", done, 1);
    step();
    chk("done_drop", done, 0);
    // neuron 0 held 36; a cleared membrane keeps 30 below threshold
    put5(6, 6, 6, 6, 6);
    get("post_done", 0, 0, 0);
    chk("done_count", done_cnt, 1);
    // reset while a packet waits in SEND
    out_ready = 0;
    put5(0, 0, 0, 0, 0);
    wait_valid();
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_ready", in_ready, 0);
    step();
    rst = 0;
    out_ready = 1;
    put5(10, 10, 10, 10, 10);
    get("after_rst", 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
